io_buffer: RTL and testbench
============================

// Module: io_buffer
// PURPOSE
//  Parametrised, buffered replacement for the core's single-byte IO in/out handshake.
//  Sits between the core (CPU_W-wide) and the serial IO device (DATA_W-wide).
//  Provides an RX FIFO (device->core) and a TX FIFO (device<-core), so the core stalls only on full/empty.
//  Accumulates device errors into a sticky status byte.
// PARAMETERS
//  DATA_W    8   device-side data width (1..CPU_W)
//  CPU_W     32  core-side data width
//  RX_DEPTH  16  RX FIFO entries (power of 2, >=2)
//  TX_DEPTH  16  TX FIFO entries (power of 2, >=2)
// PORTS
//  clk            in   1                   clock; all logic on posedge
//  rst            in   1                   synchronous reset, active-high
//  core_in_data   out  CPU_W               RX head, zero-extended from DATA_W
//  core_in_vld    out  1                   RX FIFO non-empty
//  core_in_rdy    in   1                   core pops RX head when vld&&rdy
//  core_out_data  in   CPU_W               byte to send; low DATA_W bits used
//  core_out_vld   in   1                   core push request
//  core_out_rdy   out  1                   TX FIFO not full
//  io_in_data     in   DATA_W              device receive data
//  io_in_vld      in   1                   device receive valid
//  io_in_rdy      out  1                   RX FIFO not full
//  io_out_data    out  DATA_W              TX head
//  io_out_vld     out  1                   TX FIFO non-empty
//  io_out_rdy     in   1                   device accepts TX head when vld&&rdy
//  io_err         in   5                   device error flags, sampled every cycle
//  err_clr        in   1                   clear sticky err
//  err            out  8                   sticky status
//  rx_count       out  $clog2(RX_DEPTH)+1  RX occupancy
//  tx_count       out  $clog2(TX_DEPTH)+1  TX occupancy
// BEHAVIOUR
//  - Reset: the clock and reset are decided as one clock (clk); synchronous, active-high reset (rst).
//  - Reset state: pointers/counts=0, err=0.
//  - While rst is high: core_in_vld, io_out_vld, core_out_rdy and io_in_rdy are forced to 0.
//  - Reset mid-transfer: all FIFO contents are discarded; no handshake completes on a cycle with rst high.
//  - Handshake: a transfer occurs on the edge where vld&&rdy. vld, once raised, is held with stable data until accepted.
//  - FIFOs: circular buffers. Pointers wrap modulo DEPTH; count is DEPTH+1-valued, so full = (count==DEPTH).
//  - Output path: head data read combinationally from storage at rd_ptr. Push->vld latency is 1 cycle; no bypass when empty.
//  - rdy = (count != DEPTH). There is no pass-through when full: a pop in the same cycle does not raise rdy.
//  - Simultaneous push and pop (not full, not empty): both occur; count is unchanged.
//  - Width: core_in_data = {{CPU_W-DATA_W{1'b0}}, head}. core_out_data[CPU_W-1:DATA_W] is ignored.
//  - err[4:0]: err[4:0] <= (err_clr ? 0 : err[4:0]) | io_err.
//  - err[5]: set when io_err != 0.
//  - err[6]: set when the RX FIFO reaches full.
//  - err[7]: reserved, 0.
//  - err_clr and a new event in the same cycle: the event wins (bit ends set).
// CONFIGURATION
//  Macro IO_BUFFER_LOOPBACK_EN.
//  - Defined: adds input port loopback (1 bit).
//    - When loopback=1, the TX head feeds the RX FIFO internally (TX pop = RX push when tx non-empty && rx not full).
//    - io_out_vld=0, io_in_rdy=0, and io_err is masked.
//    - Switching loopback applies from the next cycle and does not flush the FIFOs.
//  - Undefined: no loopback port; device paths are always live.
// TESTING
//  1. Reset: hold rst 2 cycles with io_in_vld=1 -> all vld/rdy=0 and counts=0 during rst; io_in_rdy=1 the cycle after release.
//  2. RX order: device sends 0x41,0x42,0x43 back-to-back with core_in_rdy=0 -> rx_count=3; then core pops 0x00000041, 0x00000042, 0x00000043 in order.
//  3. TX full: push 17 words 0x100..0x110 with io_out_rdy=0 (default depth) -> 16 accepted, core_out_rdy=0 on the 17th; device drains 0x00..0x0F; 0x110 is accepted once space frees.
//  4. Wrap: 40 continuous push/pop cycles on RX -> data sequence intact, count stays <=2, and pointers wrap twice.
//  5. Errors: io_err=5'b00100 for 1 cycle -> err=8'h24; err_clr with io_err=5'b00001 the same cycle -> err=8'h21; RX filled to 16 -> err[6]=1.
//  6. Loopback (IO_BUFFER_LOOPBACK_EN): loopback=1, push 0xAA,0x55 -> core_in_data returns 0xAA then 0x55; io_out_vld stays 0.

Source files
------------

// File: rtl/io_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : io_buffer_if
// Brief    : Core-side and device-side valid/ready channels of io_buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface io_buffer_if #(
  parameter int DATA_W = 8,
  parameter int CPU_W  = 32
);
  logic [CPU_W-1:0]  core_in_data;
  logic              core_in_vld;
  logic              core_in_rdy;
  logic [CPU_W-1:0]  core_out_data;
  logic              core_out_vld;
  logic              core_out_rdy;
  logic [DATA_W-1:0] io_in_data;
  logic              io_in_vld;
  logic              io_in_rdy;
  logic [DATA_W-1:0] io_out_data;
  logic              io_out_vld;
  logic              io_out_rdy;

  // The buffer itself is the slave; core and device together form the master.
  modport slave (
    output core_in_data, core_in_vld,
    input  core_in_rdy,
    input  core_out_data, core_out_vld,
    output core_out_rdy,
    input  io_in_data, io_in_vld,
    output io_in_rdy,
    output io_out_data, io_out_vld,
    input  io_out_rdy
  );

  modport master (
    input  core_in_data, core_in_vld,
    output core_in_rdy,
    output core_out_data, core_out_vld,
    input  core_out_rdy,
    output io_in_data, io_in_vld,
    input  io_in_rdy,
    input  io_out_data, io_out_vld,
    output io_out_rdy
  );
endinterface
`default_nettype wire

// File: rtl/io_buffer.sv
`default_nettype none
// ============================================================================
// Module   : io_buffer
// Brief    : RX/TX FIFOs between core and serial device with sticky error byte.
//            Optional internal TX->RX loopback under IO_BUFFER_LOOPBACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module io_buffer #(
  parameter int DATA_W   = 8,
  parameter int CPU_W    = 32,
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16
) (
  input  wire logic                        clk,
  input  wire logic                        rst,
`ifdef IO_BUFFER_LOOPBACK_EN
  input  wire logic                        loopback,
`endif
  io_buffer_if.slave                       bus,
  input  wire logic [4:0]                  io_err,
  input  wire logic                        err_clr,
  output logic      [7:0]                  err,
  output logic      [$clog2(RX_DEPTH):0]   rx_count,
  output logic      [$clog2(TX_DEPTH):0]   tx_count
);
  localparam int c_RX_AW = $clog2(RX_DEPTH);
  localparam int c_TX_AW = $clog2(TX_DEPTH);
  localparam int c_RX_CW = c_RX_AW + 1;
  localparam int c_TX_CW = c_TX_AW + 1;
  localparam logic [c_RX_CW-1:0] c_RX_FULL = c_RX_CW'(RX_DEPTH);
  localparam logic [c_TX_CW-1:0] c_TX_FULL = c_TX_CW'(TX_DEPTH);

  logic w_lb;

`ifdef IO_BUFFER_LOOPBACK_EN
  // Registered so a mode change takes effect from the following cycle.
  logic r_lb;
  always_ff @(posedge clk) begin
    if (rst) r_lb <= 1'b0;
    else     r_lb <= loopback;
  end
  assign w_lb = r_lb;
`else
  assign w_lb = 1'b0;
`endif

  logic [DATA_W-1:0]  r_rx_mem [RX_DEPTH];
  logic [c_RX_AW-1:0] r_rx_wr, r_rx_rd;
  logic [c_RX_CW-1:0] r_rx_count, w_rx_cnt_nxt;
  logic [DATA_W-1:0]  r_tx_mem [TX_DEPTH];
  logic [c_TX_AW-1:0] r_tx_wr, r_tx_rd;
  logic [c_TX_CW-1:0] r_tx_count, w_tx_cnt_nxt;
  logic [7:0]         r_err;

  logic              w_rx_full, w_rx_empty, w_rx_rdy, w_rx_vld;
  logic              w_tx_full, w_tx_empty, w_tx_rdy, w_tx_vld;
  logic              w_rx_push, w_rx_pop, w_tx_push, w_tx_pop, w_lb_xfer;
  logic [DATA_W-1:0] w_rx_head, w_tx_head, w_rx_din;
  logic [4:0]        w_io_err_m;
  logic [7:0]        w_err_keep;
  logic              w_rx_fill_evt;

  assign w_rx_full  = (r_rx_count == c_RX_FULL);
  assign w_rx_empty = (r_rx_count == '0);
  assign w_tx_full  = (r_tx_count == c_TX_FULL);
  assign w_tx_empty = (r_tx_count == '0);

  // Reset masks every handshake so nothing transfers while rst is high.
  assign w_rx_rdy = !rst && !w_rx_full;
  assign w_rx_vld = !rst && !w_rx_empty;
  assign w_tx_rdy = !rst && !w_tx_full;
  assign w_tx_vld = !rst && !w_tx_empty;

  assign w_rx_head = r_rx_mem[r_rx_rd];
  assign w_tx_head = r_tx_mem[r_tx_rd];

  assign w_lb_xfer = w_lb && w_tx_vld && w_rx_rdy;
  assign w_rx_push = w_lb ? w_lb_xfer : (bus.io_in_vld && w_rx_rdy);
  assign w_rx_din  = w_lb ? w_tx_head : bus.io_in_data;
  assign w_rx_pop  = w_rx_vld && bus.core_in_rdy;
  assign w_tx_push = bus.core_out_vld && w_tx_rdy;
  assign w_tx_pop  = w_lb ? w_lb_xfer : (w_tx_vld && bus.io_out_rdy);

  assign bus.core_in_data = CPU_W'(w_rx_head);
  assign bus.core_in_vld  = w_rx_vld;
  assign bus.core_out_rdy = w_tx_rdy;
  assign bus.io_in_rdy    = w_rx_rdy && !w_lb;
  assign bus.io_out_data  = w_tx_head;
  assign bus.io_out_vld   = w_tx_vld && !w_lb;

  generate
    if (CPU_W > DATA_W) begin : g_hi_unused
      logic w_unused_hi;
      assign w_unused_hi = &{1'b0, bus.core_out_data[CPU_W-1:DATA_W]};
    end
  endgenerate

  always_comb begin
    w_rx_cnt_nxt = r_rx_count;
    case ({w_rx_push, w_rx_pop})
      2'b10:   w_rx_cnt_nxt = r_rx_count + c_RX_CW'(1);
      2'b01:   w_rx_cnt_nxt = r_rx_count - c_RX_CW'(1);
      default: w_rx_cnt_nxt = r_rx_count;
    endcase
  end

  always_comb begin
    w_tx_cnt_nxt = r_tx_count;
    case ({w_tx_push, w_tx_pop})
      2'b10:   w_tx_cnt_nxt = r_tx_count + c_TX_CW'(1);
      2'b01:   w_tx_cnt_nxt = r_tx_count - c_TX_CW'(1);
      default: w_tx_cnt_nxt = r_tx_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wr] <= w_rx_din;
    if (w_tx_push) r_tx_mem[r_tx_wr] <= bus.core_out_data[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_wr    <= '0;
      r_rx_rd    <= '0;
      r_rx_count <= '0;
      r_tx_wr    <= '0;
      r_tx_rd    <= '0;
      r_tx_count <= '0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + c_RX_AW'(1);
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + c_RX_AW'(1);
      if (w_tx_push) r_tx_wr <= r_tx_wr + c_TX_AW'(1);
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + c_TX_AW'(1);
      r_rx_count <= w_rx_cnt_nxt;
      r_tx_count <= w_tx_cnt_nxt;
    end
  end

  // Fill event fires on the edge where RX becomes full, so a clear while
  // the FIFO stays full is not immediately undone.
  assign w_io_err_m    = w_lb ? 5'b0 : io_err;
  assign w_rx_fill_evt = (w_rx_cnt_nxt == c_RX_FULL) && !w_rx_full;
  assign w_err_keep    = err_clr ? 8'h00 : r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 8'h00;
    end else begin
      r_err <= {1'b0,
                w_err_keep[6] | w_rx_fill_evt,
                w_err_keep[5] | (|w_io_err_m),
                w_err_keep[4:0] | w_io_err_m};
    end
  end

  assign err      = r_err;
  assign rx_count = r_rx_count;
  assign tx_count = r_tx_count;
endmodule
`default_nettype wire

// File: tb/tb_io_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_buffer
// Brief    : Directed self-checking bench for io_buffer (default 8/32, depth 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_buffer;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] io_err;
  logic       err_clr;
  logic [7:0] err;
  logic [4:0] rx_count;
  logic [4:0] tx_count;
`ifdef IO_BUFFER_LOOPBACK_EN
  logic       loopback;
`endif
  int n_checks = 0;
  int n_fail   = 0;

  io_buffer_if #(.DATA_W(8), .CPU_W(32)) bus ();

  io_buffer #(.DATA_W(8), .CPU_W(32), .RX_DEPTH(16), .TX_DEPTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef IO_BUFFER_LOOPBACK_EN
    .loopback (loopback),
`endif
    .bus      (bus.slave),
    .io_err   (io_err),
    .err_clr  (err_clr),
    .err      (err),
    .rx_count (rx_count),
    .tx_count (tx_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic hs, acc;
    rst = 1'b1; io_err = '0; err_clr = 1'b0;
    bus.core_in_rdy = 1'b0; bus.core_out_data = '0; bus.core_out_vld = 1'b0;
    bus.io_in_data = 8'h99; bus.io_in_vld = 1'b1; bus.io_out_rdy = 1'b0;
`ifdef IO_BUFFER_LOOPBACK_EN
    loopback = 1'b0;
`endif

    // Reset held two cycles with the device already offering data
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_core_in_vld",  bus.core_in_vld,  0);
      chk("rst_io_out_vld",   bus.io_out_vld,   0);
      chk("rst_core_out_rdy", bus.core_out_rdy, 0);
      chk("rst_io_in_rdy",    bus.io_in_rdy,    0);
      chk("rst_rx_count",     rx_count,         0);
      chk("rst_tx_count",     tx_count,         0);
      chk("rst_err",          err,              0);
    end
    rst = 1'b0; bus.io_in_vld = 1'b0;
    tick();
    chk("post_rst_io_in_rdy",    bus.io_in_rdy,    1);
    chk("post_rst_core_out_rdy", bus.core_out_rdy, 1);
    chk("post_rst_rx_count",     rx_count,         0);

    // RX ordering, no bypass on empty
    bus.io_in_vld = 1'b1; bus.io_in_data = 8'h41;
    chk("rx_no_bypass", bus.core_in_vld, 0);
    tick();
    chk("rx_vld_latency", bus.core_in_vld, 1);
    bus.io_in_data = 8'h42; tick();
    bus.io_in_data = 8'h43; tick();
    bus.io_in_vld = 1'b0;
    chk("rx_count3", rx_count, 3);
    bus.core_in_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rx_pop_data", bus.core_in_data, 32'h41 + i);
      tick();
    end
    bus.core_in_rdy = 1'b0;
    chk("rx_empty_vld", bus.core_in_vld, 0);
    chk("rx_empty_cnt", rx_count, 0);

    // TX fill past depth, then drain with the 17th word waiting
    bus.core_out_vld = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.core_out_data = 32'h100 + i;
      chk("tx_fill_rdy", bus.core_out_rdy, 1);
      tick();
    end
    bus.core_out_data = 32'h110;
    chk("tx_full_rdy",  bus.core_out_rdy, 0);
    chk("tx_full_cnt",  tx_count, 16);
    chk("tx_full_ovld", bus.io_out_vld, 1);
    bus.io_out_rdy = 1'b1; acc = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("tx_drain_data", bus.io_out_data, i);
      hs = bus.core_out_vld && bus.core_out_rdy;
      if (i == 0) chk("tx_no_passthru", bus.core_out_rdy, 0);
      tick();
      if (hs) begin
        acc = 1'b1; bus.core_out_vld = 1'b0;
      end
    end
    chk("tx_late_accept", acc, 1);
    chk("tx_late_cnt",    tx_count, 1);
    chk("tx_late_data",   bus.io_out_data, 8'h10);
    tick();
    bus.io_out_rdy = 1'b0;
    chk("tx_drained_cnt", tx_count, 0);
    chk("tx_drained_vld", bus.io_out_vld, 0);

    // RX wrap: 40 continuous cycles of push with concurrent pop
    bus.core_in_rdy = 1'b1; bus.io_in_vld = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.io_in_data = 8'h60 + 8'(i);
      tick();
      chk("wrap_count", rx_count, 1);
      chk("wrap_data",  bus.core_in_data, 32'h60 + i);
    end
    bus.io_in_vld = 1'b0;
    tick();
    bus.core_in_rdy = 1'b0;
    chk("wrap_final_cnt", rx_count, 0);

    // Sticky errors
    chk("err_idle", err, 8'h00);
    io_err = 5'b00100; tick(); io_err = '0;
    chk("err_set", err, 8'h24);
    tick();
    chk("err_sticky", err, 8'h24);
    err_clr = 1'b1; io_err = 5'b00001; tick();
    err_clr = 1'b0; io_err = '0;
    chk("err_clr_vs_event", err, 8'h21);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("err_cleared", err, 8'h00);

    bus.io_in_vld = 1'b1;
    for (int i = 0; i < 15; i++) begin
      bus.io_in_data = 8'hC0 + 8'(i);
      tick();
    end
    chk("err_before_full", err, 8'h00);
    bus.io_in_data = 8'hCF; tick();
    chk("rx_full_cnt",   rx_count, 16);
    chk("rx_full_rdy",   bus.io_in_rdy, 0);
    chk("rx_full_err",   err, 8'h40);
    chk("rx_full_head",  bus.core_in_data, 32'hC0);
    bus.io_in_data = 8'hEE; tick();
    chk("rx_full_hold", rx_count, 16);
    bus.core_in_rdy = 1'b1; tick(); bus.core_in_rdy = 1'b0;
    chk("rx_full_pop_cnt",  rx_count, 15);
    chk("rx_full_pop_head", bus.core_in_data, 32'hC1);

    // Reset mid-transfer discards contents
    bus.core_out_vld = 1'b1; bus.core_out_data = 32'h77;
    rst = 1'b1; tick();
    chk("midrst_rx_cnt", rx_count, 0);
    chk("midrst_tx_cnt", tx_count, 0);
    chk("midrst_err",    err, 8'h00);
    rst = 1'b0; bus.io_in_vld = 1'b0; bus.core_out_vld = 1'b0;
    chk("midrst_core_in_vld", bus.core_in_vld, 0);
    chk("midrst_io_out_vld",  bus.io_out_vld, 0);

`ifdef IO_BUFFER_LOOPBACK_EN
    loopback = 1'b1; tick();
    io_err = 5'b00010;
    bus.core_out_vld = 1'b1; bus.core_out_data = 32'hAA; tick();
    chk("lb_out_vld0", bus.io_out_vld, 0);
    bus.core_out_data = 32'h55; tick();
    bus.core_out_vld = 1'b0;
    chk("lb_out_vld1", bus.io_out_vld, 0);
    chk("lb_in_rdy",   bus.io_in_rdy, 0);
    tick(); tick();
    io_err = '0;
    chk("lb_rx_cnt",  rx_count, 2);
    chk("lb_tx_cnt",  tx_count, 0);
    chk("lb_data0",   bus.core_in_data, 32'hAA);
    chk("lb_err_mask", err, 8'h00);
    bus.core_in_rdy = 1'b1; tick(); bus.core_in_rdy = 1'b0;
    chk("lb_data1",   bus.core_in_data, 32'h55);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
